color_frame_classifier: RTL
===========================

COLOR_FRAME_CLASSIFIER -- requirements
Module: color_frame_classifier

Interface
REQ-001 Parameter CNT_W, default 15, width of the per-colour pixel counters (176x144 = 25344 fits).
REQ-002 Parameter MIN_PIX, default 500, minimum winning-colour pixel count for a frame to be classified.
REQ-003 Parameter VOTE_FRAMES, default 2, range 1..15, consecutive identical frame classes required to change COLOR.
REQ-004 Parameter R_MIN, default 3'd5, red-field threshold.
REQ-005 Parameter B_MIN, default 2'd2, blue-field threshold.
REQ-006 CLK  input  1  single clock; all logic on rising edge.
REQ-007 RESET  input  1  asynchronous, active-high reset.
REQ-008 VGA_VSYNC_NEG  input  1  active-low vertical sync, synchronous to CLK.
REQ-009 PIXEL_VALID  input  1  PIXEL_IN carries a valid pixel this cycle.
REQ-010 PIXEL_IN  input  8  RGB332 pixel: R=[7:5], G=[4:2], B=[1:0].
REQ-011 COLOR  output  2  voted class: 2'b00 none, 2'b01 red, 2'b10 blue; 2'b11 never driven.
REQ-012 FRAME_DONE  output  1  one-cycle pulse per completed frame decision.
REQ-013 RED_COUNT  output  CNT_W  red pixel count of last completed frame.
REQ-014 BLUE_COUNT  output  CNT_W  blue pixel count of last completed frame.

Function
REQ-015 Pixel classes: red when R>=R_MIN and B<B_MIN; blue when B>=B_MIN and R<R_MIN; otherwise neither (mutually exclusive).
REQ-016 Frame boundary is a falling edge of VGA_VSYNC_NEG: registered previous sample 1, current sample 0; edge-detect register resets to 1.
REQ-017 FSM states WAIT_SYNC, ACCUM, DECIDE, UPDATE; reset enters WAIT_SYNC.
REQ-018 WAIT_SYNC -> ACCUM on first frame boundary; no decision for the partial frame preceding it.
REQ-019 ACCUM: each cycle with PIXEL_VALID=1 increments the matching counter by 1; counters saturate at 2^CNT_W-1.
REQ-020 ACCUM -> DECIDE at the edge E0 where the boundary is detected; the pixel sampled at E0 is not counted.
REQ-021 DECIDE (edge E1): frame class = red if red>blue and red>=MIN_PIX; blue if blue>red and blue>=MIN_PIX; else none (ties, including 0=0, give none); RED_COUNT/BLUE_COUNT load counter values; -> UPDATE.
REQ-022 UPDATE (edge E2): vote applied, FRAME_DONE=1 for exactly the following cycle, both counters cleared, -> ACCUM.
REQ-023 Vote: if frame class equals candidate, run count increments, saturating at VOTE_FRAMES; else candidate = frame class and run = 1.
REQ-024 COLOR loads candidate at E2 when post-update run equals VOTE_FRAMES; otherwise COLOR holds.
REQ-025 VOTE_FRAMES=1: COLOR follows every frame class at E2.
REQ-026 PIXEL_VALID and frame boundaries during DECIDE/UPDATE are ignored.
REQ-027 VGA_VSYNC_NEG held constant: FSM stays in ACCUM, counters saturate, no FRAME_DONE.

Reset
REQ-028 RESET=1 asynchronously forces: state WAIT_SYNC, counters 0, RED_COUNT 0, BLUE_COUNT 0, COLOR 2'b00, FRAME_DONE 0, candidate none, run 0.
REQ-029 Reset asserted mid-frame or mid-DECIDE/UPDATE discards that frame; no FRAME_DONE until a full frame follows a new boundary.
REQ-030 After RESET deasserts, no counting occurs before the first frame boundary.

Verification
REQ-031 Reset, one boundary, 800 pixels 8'hE0, 100 pixels 8'h03, boundary -> FRAME_DONE 2 cycles after edge, RED_COUNT=800, BLUE_COUNT=100, COLOR stays 00; repeat frame -> COLOR=01.
REQ-032 Frames with red=blue=600, then red=400 blue=0 -> frame class none both times; COLOR 00.
REQ-033 Two red frames, then blue, red, blue frames (VOTE_FRAMES=2) -> COLOR 01 held; two consecutive blue frames -> COLOR 10.
REQ-034 CNT_W=4, 20 red pixels in one frame -> RED_COUNT=15, no wrap.
REQ-035 RESET pulsed mid-frame after 300 red pixels -> outputs zero immediately; next boundary produces no FRAME_DONE; following full frame counts from 0.
REQ-036 Pixels 8'hA2 (R=5, B=2) and 8'h83 (R=4, B=3) -> counted neither and blue respectively.

Source files
------------

// File: rtl/color_frame_classifier.sv
// Per-frame red/blue pixel classifier for RGB332 video with a consecutive-frame
// vote that filters single-frame flicker before COLOR changes.
module color_frame_classifier #(
  parameter int unsigned CNT_W       = 15,
  parameter int unsigned MIN_PIX     = 500,
  parameter int unsigned VOTE_FRAMES = 2,
  parameter logic [2:0]  R_MIN       = 3'd5,
  parameter logic [1:0]  B_MIN       = 2'd2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             VGA_VSYNC_NEG,
  input  logic             PIXEL_VALID,
  input  logic [7:0]       PIXEL_IN,
  output logic [1:0]       COLOR,
  output logic             FRAME_DONE,
  output logic [CNT_W-1:0] RED_COUNT,
  output logic [CNT_W-1:0] BLUE_COUNT
);

  typedef enum logic [1:0] {WAIT_SYNC, ACCUM, DECIDE, UPDATE} state_t;

  localparam logic [1:0]       CLS_NONE = 2'b00;
  localparam logic [1:0]       CLS_RED  = 2'b01;
  localparam logic [1:0]       CLS_BLUE = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       VOTE_N   = 4'(VOTE_FRAMES);

  state_t           state, state_next;
  logic             vsync_prev;
  logic             boundary;
  logic             pix_red, pix_blue;
  logic             count_en, clear_en, decide_en, update_en;
  logic [CNT_W-1:0] red_cnt, blue_cnt;
  logic [31:0]      red_ext, blue_ext;
  logic [1:0]       class_now, frame_class;
  logic [1:0]       cand, cand_next;
  logic [3:0]       run, run_next;

  assign boundary = vsync_prev & ~VGA_VSYNC_NEG;
  assign pix_red  = (PIXEL_IN[7:5] >= R_MIN) && (PIXEL_IN[1:0] <  B_MIN);
  assign pix_blue = (PIXEL_IN[1:0] >= B_MIN) && (PIXEL_IN[7:5] <  R_MIN);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= WAIT_SYNC;
      vsync_prev <= 1'b1;
    end else begin
      state      <= state_next;
      vsync_prev <= VGA_VSYNC_NEG;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      WAIT_SYNC: if (boundary) state_next = ACCUM;
      ACCUM:     if (boundary) state_next = DECIDE;
      DECIDE:    state_next = UPDATE;
      UPDATE:    state_next = ACCUM;
      default:   state_next = WAIT_SYNC;
    endcase
  end

  always_comb begin
    count_en  = (state == ACCUM) && !boundary && PIXEL_VALID;
    clear_en  = (state == WAIT_SYNC) || (state == UPDATE);
    decide_en = (state == DECIDE);
    update_en = (state == UPDATE);
  end

  // Ties (including 0 vs 0) fall through to none.
  always_comb begin
    red_ext   = 32'(red_cnt);
    blue_ext  = 32'(blue_cnt);
    class_now = CLS_NONE;
    if (red_ext > blue_ext && red_ext >= MIN_PIX)
      class_now = CLS_RED;
    else if (blue_ext > red_ext && blue_ext >= MIN_PIX)
      class_now = CLS_BLUE;
  end

  always_comb begin
    cand_next = frame_class;
    run_next  = 4'd1;
    if (frame_class == cand) begin
      cand_next = cand;
      run_next  = (run >= VOTE_N) ? VOTE_N : run + 4'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      red_cnt     <= '0;
      blue_cnt    <= '0;
      RED_COUNT   <= '0;
      BLUE_COUNT  <= '0;
      frame_class <= CLS_NONE;
      cand        <= CLS_NONE;
      run         <= '0;
      COLOR       <= CLS_NONE;
      FRAME_DONE  <= 1'b0;
    end else begin
      FRAME_DONE <= update_en;
      if (clear_en) begin
        red_cnt  <= '0;
        blue_cnt <= '0;
      end else if (count_en) begin
        if (pix_red && red_cnt != CNT_MAX)   red_cnt  <= red_cnt + 1'b1;
        if (pix_blue && blue_cnt != CNT_MAX) blue_cnt <= blue_cnt + 1'b1;
      end
      if (decide_en) begin
        frame_class <= class_now;
        RED_COUNT   <= red_cnt;
        BLUE_COUNT  <= blue_cnt;
      end
      if (update_en) begin
        cand <= cand_next;
        run  <= run_next;
        if (run_next == VOTE_N) COLOR <= cand_next;
      end
    end
  end

endmodule
